// File: rtl/lmem_arbiter.sv
// Round-robin arbiter for the shared layer-memory port.
// Three requesters (conv layer-0 writes, max-pool, host readback) compete for
// one access per cycle. The winner's command is registered onto the memory
// port and read data is steered back to the issuing requester via a tag pipe.
// A requester may hold a bounded locked burst so gathers are not interleaved.
module lmem_arbiter #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [2:0]  we,
  input  logic [8:0]  sel,
  input  logic [35:0] addr,
  input  logic [59:0] wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  rvalid,
  output logic [19:0] rdata,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic [2:0]  csel
);

  localparam int unsigned CntW     = $clog2(MAX_LOCK + 1);
  localparam int unsigned TagDepth = RD_LAT + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LOCK);

  // Arbitration state
  logic [1:0]      ptr_q, ptr_d;
  logic            lock_vld_q, lock_vld_d;
  logic [1:0]      lock_id_q, lock_id_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;

  // Winner decode
  logic       any_req;
  logic       grant;
  logic       lock_cont;
  logic       others;
  logic [1:0] win_id;
  logic [2:0] win_oh;
  logic       win_we;
  logic [2:0] win_sel;
  logic [11:0] win_addr;
  logic [19:0] win_wdata;

  // Registered memory command
  logic        cwr_q, crd_q;
  logic [11:0] caddr_wr_q, caddr_rd_q;
  logic [19:0] cdata_wr_q;
  logic [2:0]  csel_q;

  // Read tag pipeline and return registers
  logic [TagDepth-1:0]      tag_vld_q;
  logic [TagDepth-1:0][1:0] tag_id_q;
  logic [2:0]               rvalid_q;
  logic [19:0]              rdata_q;

  // First requesting index at or after p, wrapping modulo 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] s;
    logic [1:0] pick;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, p} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (!found && r[s[1:0]]) begin
        pick  = s[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pick the winner: a live, unexhausted lock beats round-robin.
  always_comb begin
    any_req   = |req;
    lock_cont = lock_vld_q && req[lock_id_q] && lock[lock_id_q] && (lock_cnt_q < MaxCnt);
    if (lock_cont) begin
      win_id = lock_id_q;
    end else begin
      win_id = rr_pick(req, ptr_q);
    end
    win_oh = 3'b001 << win_id;
    grant  = any_req && !reset;
    gnt    = grant ? win_oh : 3'b000;
    others = |(req & ~win_oh);
  end

  // Route the winning requester's command fields.
  always_comb begin
    win_we    = 1'b0;
    win_sel   = '0;
    win_addr  = '0;
    win_wdata = '0;
    unique case (win_id)
      2'd0: begin
        win_we    = we[0];
        win_sel   = sel[2:0];
        win_addr  = addr[11:0];
        win_wdata = wdata[19:0];
      end
      2'd1: begin
        win_we    = we[1];
        win_sel   = sel[5:3];
        win_addr  = addr[23:12];
        win_wdata = wdata[39:20];
      end
      default: begin
        win_we    = we[2];
        win_sel   = sel[8:6];
        win_addr  = addr[35:24];
        win_wdata = wdata[59:40];
      end
    endcase
  end

  // Next pointer and lock bookkeeping.
  always_comb begin
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    lock_cnt_d = lock_cnt_q;
    if (grant) begin
      // Locked continuations leave the round-robin position untouched.
      if (!lock_cont) ptr_d = (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
      if (lock[win_id]) begin
        lock_vld_d = 1'b1;
        lock_id_d  = win_id;
        if (lock_cont) begin
          // Only grants that actually starve someone count toward the bound.
          lock_cnt_d = others ? lock_cnt_q + CntW'(1) : lock_cnt_q;
        end else begin
          lock_cnt_d = others ? CntW'(1) : '0;
        end
      end else begin
        lock_vld_d = 1'b0;
        lock_cnt_d = '0;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= 2'd0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 2'd0;
      lock_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Issue the granted command one cycle after the grant; fields hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= '0;
    end else begin
      cwr_q <= grant & win_we;
      crd_q <= grant & ~win_we;
      if (grant) begin
        csel_q <= win_sel;
        if (win_we) begin
          caddr_wr_q <= win_addr;
          cdata_wr_q <= win_wdata;
        end else begin
          caddr_rd_q <= win_addr;
        end
      end
    end
  end

  // Carry the read owner alongside the memory latency; stage 0 lines up with crd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= grant & ~win_we;
      tag_id_q[0]  <= win_id;
      for (int k = 1; k < TagDepth; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // Capture returning data and strobe it to its owner; rdata holds between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (tag_vld_q[RD_LAT]) begin
        rvalid_q <= 3'b001 << tag_id_q[RD_LAT];
        rdata_q  <= cdata_rd;
      end
    end
  end

  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;
  assign csel     = csel_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared against an in-bench behavioural model.
module tb_lmem_arbiter;

  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned MAX_LOCK = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0, lock = '0, we = '0;
  logic [8:0]  sel = '0;
  logic [35:0] addr = '0;
  logic [59:0] wdata = '0;
  logic [2:0]  gnt, rvalid, csel;
  logic [19:0] rdata, cdata_wr, cdata_rd;
  logic        cwr, crd;
  logic [11:0] caddr_wr, caddr_rd;

  always #5 clk = ~clk;

  lmem_arbiter #(.RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .sel      (sel),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel)
  );

  // Read-only memory with RD_LAT latency; junk on the bus when not reading.
  logic [19:0] mem [4096];
  logic [19:0] mem_pipe [RD_LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= crd ? mem[caddr_rd] : 20'($urandom);
    for (int k = 1; k < RD_LAT; k++) mem_pipe[k] <= mem_pipe[k-1];
  end
  assign cdata_rd = mem_pipe[RD_LAT-1];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Behavioural model state
  int m_ptr, m_owner, m_cnt, m_win;
  logic m_cont;
  logic [2:0]  e_gnt;
  logic        e_cwr, e_crd;
  logic [11:0] e_awr, e_ard;
  logic [19:0] e_dwr, e_rdata;
  logic [2:0]  e_csel;
  typedef struct {int id; logic [19:0] data; int due;} ret_t;
  ret_t rq[$];

  logic [2:0]  t3_seq [6];
  logic [11:0] t4_addr [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [35:0] a3(input logic [11:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [59:0] d3(input logic [19:0] d0, d1, d2);
    return {d2, d1, d0};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_cnt = 0; m_win = -1; m_cont = 1'b0;
    e_gnt = '0; e_cwr = 1'b0; e_crd = 1'b0; e_awr = '0; e_ard = '0;
    e_dwr = '0; e_rdata = '0; e_csel = '0;
    rq.delete();
  endtask

  task automatic model_arb(input logic [2:0] r, input logic [2:0] l);
    m_cont = 1'b0;
    if (m_owner >= 0) m_cont = r[m_owner] && l[m_owner] && (m_cnt < MAX_LOCK);
    m_win = -1;
    if (m_cont) m_win = m_owner;
    else for (int k = 0; k < 3; k++) if (m_win < 0 && r[(m_ptr + k) % 3]) m_win = (m_ptr + k) % 3;
    e_gnt = (m_win < 0) ? 3'b000 : 3'(1 << m_win);
  endtask

  task automatic model_update(input logic [2:0] r, l, w, input logic [8:0] s,
                              input logic [35:0] a, input logic [59:0] d);
    bit others;
    e_cwr = 1'b0;
    e_crd = 1'b0;
    if (m_win >= 0) begin
      others = (r & ~e_gnt) != 3'b000;
      if (!m_cont) m_ptr = (m_win + 1) % 3;
      if (l[m_win]) begin
        if (m_cont) begin
          if (others) m_cnt++;
        end else m_cnt = others ? 1 : 0;
        m_owner = m_win;
      end else begin
        m_owner = -1;
        m_cnt = 0;
      end
      e_csel = s[m_win*3 +: 3];
      if (w[m_win]) begin
        e_cwr = 1'b1;
        e_awr = a[m_win*12 +: 12];
        e_dwr = d[m_win*20 +: 20];
      end else begin
        e_crd = 1'b1;
        e_ard = a[m_win*12 +: 12];
        rq.push_back('{m_win, mem[a[m_win*12 +: 12]], cyc + 2 + RD_LAT});
      end
    end
  endtask

  task automatic check_regs();
    logic [2:0] erv;
    erv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      erv = 3'(1 << rq[0].id);
      e_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("rdata", 64'(rdata), 64'(e_rdata));
    chk("cwr", 64'(cwr), 64'(e_cwr));
    chk("crd", 64'(crd), 64'(e_crd));
    chk("caddr_wr", 64'(caddr_wr), 64'(e_awr));
    chk("caddr_rd", 64'(caddr_rd), 64'(e_ard));
    chk("cdata_wr", 64'(cdata_wr), 64'(e_dwr));
    chk("csel", 64'(csel), 64'(e_csel));
  endtask

  // One clock: check registered outputs, drive, check the combinational grant.
  task automatic step(input logic [2:0] r, l, w, input logic [8:0] s,
                      input logic [35:0] a, input logic [59:0] d);
    @(posedge clk);
    cyc++;
    #1;
    check_regs();
    req = r; lock = l; we = w; sel = s; addr = a; wdata = d;
    #1;
    model_arb(r, l);
    chk("gnt", 64'(gnt), 64'(e_gnt));
    model_update(r, l, w, s, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_gnt"}, 64'(gnt), 64'd0);
    chk({name, "_rvalid"}, 64'(rvalid), 64'd0);
    chk({name, "_rdata"}, 64'(rdata), 64'd0);
    chk({name, "_cwr_crd"}, 64'({cwr, crd}), 64'd0);
    chk({name, "_caddr"}, 64'({caddr_wr, caddr_rd}), 64'd0);
    chk({name, "_cdata_wr"}, 64'(cdata_wr), 64'd0);
    chk({name, "_csel"}, 64'(csel), 64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle with whatever is in flight.
  task automatic reset_mid();
    #1 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    req = '0; lock = '0; we = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [2:0] burst;
    logic [2:0] r;
    for (int i = 0; i < 4096; i++) mem[i] = 20'((i * 32'h0B3D7) ^ 32'h5A5A5);
    mem[12'h7FF] = 20'hABCDE;
    t3_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    t4_addr = '{12'h000, 12'h001, 12'h040, 12'h041};
    model_reset();

    // Reset state, with all requests raised.
    #2 reset = 1'b1;
    req = 3'b111;
    @(posedge clk);
    @(posedge clk);
    #1 check_all_zero("reset");
    req = '0;
    @(negedge clk) reset = 1'b0;

    // 1: single write
    step(3'b001, 3'b000, 3'b001, 9'd1, a3(12'h041, 0, 0), d3(20'h01310, 0, 0));
    chk("t1_gnt", 64'(gnt), 64'b001);
    idle(1);
    chk("t1_cwr", 64'(cwr), 64'd1);
    chk("t1_crd", 64'(crd), 64'd0);
    chk("t1_caddr_wr", 64'(caddr_wr), 64'h041);
    chk("t1_cdata_wr", 64'(cdata_wr), 64'h01310);
    chk("t1_csel", 64'(csel), 64'd1);
    idle(1);
    chk("t1_cwr_off", 64'(cwr), 64'd0);

    // 2: read latency from requester 2
    step(3'b100, 3'b000, 3'b000, 9'(3'd5 << 6), a3(0, 0, 12'h7FF), '0);
    chk("t2_gnt", 64'(gnt), 64'b100);
    idle(1);
    chk("t2_crd", 64'(crd), 64'd1);
    chk("t2_caddr_rd", 64'(caddr_rd), 64'h7FF);
    chk("t2_rvalid_early", 64'(rvalid), 64'd0);
    idle(1);
    chk("t2_rvalid_early2", 64'(rvalid), 64'd0);
    idle(1);
    chk("t2_rvalid", 64'(rvalid), 64'b100);
    chk("t2_rdata", 64'(rdata), 64'hABCDE);
    idle(1);
    chk("t2_rvalid_off", 64'(rvalid), 64'd0);

    // 3: round-robin fairness with everyone requesting
    for (int i = 0; i < 7; i++) begin
      if (i < 6) step(3'b111, 3'b000, 3'b101, 9'o421, a3(12'h010, 12'h020, 12'h030),
                      d3(20'h1, 20'h2, 20'h3));
      else idle(1);
      if (i < 6) chk("t3_gnt", 64'(gnt), 64'(t3_seq[i]));
      if (i > 0) chk("t3_strobe", 64'(cwr | crd), 64'd1);
    end
    idle(4);

    // 4: locked 2x2 gather by requester 1 while requester 0 waits
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(3'b010, 3'b010, 3'b000, '0, a3(0, t4_addr[0], 0), '0);
      else if (i < 4) step(3'b011, 3'b010, 3'b001, '0, a3(12'h100, t4_addr[i], 0),
                           d3(20'h77, 0, 0));
      else if (i == 4) step(3'b001, 3'b000, 3'b001, '0, a3(12'h100, 0, 0), d3(20'h77, 0, 0));
      else idle(1);
      if (i < 4) chk("t4_gnt_lock", 64'(gnt), 64'b010);
      if (i == 4) chk("t4_gnt_release", 64'(gnt), 64'b001);
      if (i >= 3 && i <= 6) begin
        chk("t4_rvalid", 64'(rvalid), 64'b010);
        chk("t4_rdata", 64'(rdata), 64'(mem[t4_addr[i-3]]));
      end
    end
    idle(4);

    // 5: lock bound against a persistent competitor
    for (int i = 0; i < 34; i++) begin
      step(3'b110, 3'b010, 3'b100, '0, a3(0, 12'(i), 12'h200), d3(0, 0, 20'(i)));
      chk("t5_gnt", 64'(gnt), (i == 16 || i == 33) ? 64'b100 : 64'b010);
    end
    step(3'b111, 3'b000, 3'b111, '0, '0, '0);
    chk("t5_ptr", 64'(gnt), 64'b001);
    idle(4);

    // 6: reset with two reads in flight
    step(3'b001, 3'b000, 3'b000, '0, a3(12'h005, 0, 0), '0);
    step(3'b010, 3'b000, 3'b000, '0, a3(0, 12'h006, 0), '0);
    reset_mid();
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("t6_no_rvalid", 64'(rvalid), 64'd0);
    end
    step(3'b100, 3'b000, 3'b000, '0, a3(0, 0, 12'h7FF), '0);
    chk("t6_gnt", 64'(gnt), 64'b100);
    idle(3);
    chk("t6_rvalid", 64'(rvalid), 64'b100);
    chk("t6_rdata", 64'(rdata), 64'hABCDE);
    idle(2);

    // Randomized traffic with sticky lock bursts and one mid-run reset
    burst = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(15) == 0) burst[i] = ~burst[i];
        if (n >= 600 && n < 800) r[i] = ($urandom_range(2) == 0);
        else r[i] = ($urandom_range(7) != 0);
      end
      step(r, burst, 3'($urandom), 9'($urandom), 36'({$urandom(), $urandom()}),
           60'({$urandom(), $urandom()}));
      if (n == 700) reset_mid();
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lmem_arbiter.md
Name: lmem_arbiter

Overview:
- Round-robin arbiter that shares the single layer-memory port (cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd/csel) among three requesters:
  - requester 0: conv engine layer-0 writes
  - requester 1: max-pool reads and writes
  - requester 2: host/debug readback
- Grants one access per cycle, registers the memory command and routes read data back to the issuing requester.
- Supports bounded locked bursts so the pooling 2x2 read gather is not interleaved.

Parameters:
- RD_LAT, 1: cycles from a crd cycle to valid cdata_rd (1..4).
- MAX_LOCK, 16: maximum consecutive locked grants to one requester while another requester is pending.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  3  per-requester access request, bit i = requester i.
- lock  input  3  per-requester burst lock; only meaningful while req[i]=1.
- we  input  3  per-requester write (1) / read (0).
- sel  input  9  csel value, 3 bits per requester ([3i+2:3i]).
- addr  input  36  memory address, 12 bits per requester.
- wdata  input  60  write data, 20 bits per requester.
- gnt  output  3  one-hot, combinational accept in the request cycle.
- rvalid  output  3  one-hot read-return strobe.
- rdata  output  20  read data, shared by all requesters, qualified by rvalid.
- cwr  output  1  memory write strobe.
- caddr_wr  output  12  memory write address.
- cdata_wr  output  20  memory write data.
- crd  output  1  memory read strobe.
- caddr_rd  output  12  memory read address.
- cdata_rd  input  20  memory read data.
- csel  output  3  memory bank select.

Behaviour:
- Reset: all outputs 0; ptr=0; lock_owner=none; lock_cnt=0; read pipeline emptied. Reset mid-operation drops any in-flight reads, and no rvalid is produced for them.
- Arbitration, cycle N (combinational):
  - If lock_owner=i, req[i]=1, lock[i]=1 and lock_cnt<MAX_LOCK, requester i wins.
  - Otherwise the winner is the first requester with req set, searching from ptr upward modulo 3.
  - gnt[winner]=1 in cycle N; at most one gnt bit is high. No req → gnt=0.
  - The requester treats gnt=1 as accepted; it may change req/addr at the next edge.
- Pointer update at the end of N:
  - ptr ← winner+1 mod 3 on any grant.
  - A locked continuation does not change ptr.
- Lock state:
  - lock_owner ← winner if lock[winner]=1, else none.
  - lock_cnt increments on each consecutive locked grant to the same owner and clears on an owner change or an unlocked grant.
  - lock_cnt saturates at MAX_LOCK. Reaching it forces normal round-robin for one arbitration, then lock_cnt clears.
  - If no other requester is pending, the lock continues and the count does not saturate.
- Command issue, cycle N+1 (registered):
  - On a write: cwr=1, caddr_wr=addr[winner], cdata_wr=wdata[winner], csel=sel[winner].
  - On a read: crd=1, caddr_rd=addr[winner], csel=sel[winner].
  - cwr and crd are high for exactly one cycle per grant and are never both high.
  - Address, data and csel registers hold their last value when idle.
- Read return:
  - A tag pipeline of depth RD_LAT+1 carries the requester id and a valid bit.
  - cdata_rd is sampled in cycle N+1+RD_LAT.
  - rvalid[id]=1 and rdata=sampled value in cycle N+2+RD_LAT, for one cycle.
  - Back-to-back reads return in issue order, one per cycle.
  - rdata holds its value between returns.
- Throughput: one grant per cycle sustained. Writes and reads may alternate every cycle.
- Write-after-read: the memory orders accesses by port. Bypass is the requester's responsibility.
- Out-of-range inputs: bits of lock/we/sel/addr/wdata with req[i]=0 are ignored.

Test Plan:
1. Single write: req=001, we=001, addr0=12'h041, wdata0=20'h01310, sel0=1 → gnt=001 same cycle; next cycle cwr=1, caddr_wr=041, cdata_wr=01310, csel=1, crd=0; following cycle cwr=0.
2. Read latency (RD_LAT=1): requester 2 reads addr 12'h7FF; memory returns 20'hABCDE in the cycle after crd → rvalid=100, rdata=ABCDE exactly 3 cycles after gnt; no other rvalid bit set.
3. Round-robin fairness: req=111 held for 6 cycles, ptr=0 after reset → gnt sequence 001,010,100,001,010,100; memory sees 6 consecutive one-cycle strobes.
4. Locked burst: requester 1 issues 4 reads to 000,001,040,041 with lock=1 while req0=1 → gnt 010 ×4, then 001; rvalid 010 ×4 in order with matching data.
5. Lock bound: MAX_LOCK=16, req1+lock1 held, req2 held → 16 grants to 1, then 1 grant to 2, then locking resumes; ptr check passes.
6. Reset mid-read: assert reset while 2 reads are in flight → all outputs 0 immediately; after release no rvalid; a fresh req=100 read completes normally.
